// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - D/E/M hazard and mult/div occupancy signals between pipeline and hazard_ctrl
interface hazard_ctrl_if;
  logic [4:0] rsD;
  logic [4:0] rtD;
  logic [1:0] tuse_rsD;
  logic [1:0] tuse_rtD;
  logic [4:0] waE;
  logic       regwE;
  logic [2:0] tnewE;
  logic [4:0] waM;
  logic       regwM;
  logic [2:0] tnewM;
  logic       md_startE;
  logic       md_opE;
  logic       md_useD;
  logic       stall;
  logic       flushE;
  logic       md_busy;

  modport master (
    output rsD, rtD, tuse_rsD, tuse_rtD,
    output waE, regwE, tnewE, waM, regwM, tnewM,
    output md_startE, md_opE, md_useD,
    input  stall, flushE, md_busy
  );

  modport slave (
    input  rsD, rtD, tuse_rsD, tuse_rtD,
    input  waE, regwE, tnewE, waM, regwM, tnewM,
    input  md_startE, md_opE, md_useD,
    output stall, flushE, md_busy
  );
endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - Tuse/Tnew stall and flush generation with mult/div busy tracking; HAZARD_STALL_CNT_EN adds a saturating stall counter
module hazard_ctrl (
  input  logic               clk,
  input  logic               reset,
  hazard_ctrl_if.slave       hz
`ifdef HAZARD_STALL_CNT_EN
  ,
  output logic [31:0]        stall_cnt
`endif
);

  logic       stallRs;
  logic       stallRt;
  logic       stallMd;
  logic       stallAll;
  logic [3:0] busyCnt;

  // tuse is widened to tnew's width; tuse = 3 can never be exceeded since tnew <= 3
  always_comb begin
    stallRs = (hz.rsD != 5'd0) &&
              ((hz.regwE && (hz.waE == hz.rsD) && (hz.tnewE > {1'b0, hz.tuse_rsD})) ||
               (hz.regwM && (hz.waM == hz.rsD) && (hz.tnewM > {1'b0, hz.tuse_rsD})));
    stallRt = (hz.rtD != 5'd0) &&
              ((hz.regwE && (hz.waE == hz.rtD) && (hz.tnewE > {1'b0, hz.tuse_rtD})) ||
               (hz.regwM && (hz.waM == hz.rtD) && (hz.tnewM > {1'b0, hz.tuse_rtD})));
    stallMd = hz.md_useD && ((busyCnt != 4'd0) || hz.md_startE);
    stallAll = stallRs || stallRt || stallMd;
  end

  assign hz.stall   = stallAll;
  assign hz.flushE  = stallAll;
  assign hz.md_busy = (busyCnt != 4'd0);

  // A new start reloads the counter even while busy: the last start wins
  always_ff @(posedge clk) begin
    if (reset) begin
      busyCnt <= 4'd0;
    end else if (hz.md_startE) begin
      busyCnt <= hz.md_opE ? 4'd10 : 4'd5;
    end else if (busyCnt != 4'd0) begin
      busyCnt <= busyCnt - 4'd1;
    end
  end

`ifdef HAZARD_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= 32'd0;
    end else if (stallAll && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed and randomized checks of hazard_ctrl against a cycle-indexed reference model
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  hazard_ctrl_if hz();
`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  hazard_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
`ifdef HAZARD_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  int     vectors = 0;
  int     miscompares = 0;
  int     cyc = 0;
  int     busyEnd = -1;
  longint mCnt = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic bit srcHazard(input logic [4:0] r, input logic [1:0] tuse);
    int need;
    need = int'(tuse);
    if (r == 5'd0) return 1'b0;
    if (hz.regwE && hz.waE == r && int'(hz.tnewE) > need) return 1'b1;
    if (hz.regwM && hz.waM == r && int'(hz.tnewM) > need) return 1'b1;
    return 1'b0;
  endfunction

  // busyEnd is the last cycle index in which the mult/div unit is occupied
  task automatic step(input int expStall, input int expBusy);
    bit eStall;
    bit eBusy;
    @(negedge clk);
    eBusy  = (cyc <= busyEnd);
    eStall = srcHazard(hz.rsD, hz.tuse_rsD) || srcHazard(hz.rtD, hz.tuse_rtD) ||
             (hz.md_useD && (eBusy || hz.md_startE));
    check("stall", hz.stall, eStall);
    check("flushE", hz.flushE, eStall);
    check("md_busy", hz.md_busy, eBusy);
`ifdef HAZARD_STALL_CNT_EN
    check("stall_cnt", stall_cnt, mCnt[31:0]);
`endif
    if (expStall >= 0) check("stall_literal", hz.stall, expStall[0]);
    if (expBusy >= 0) check("md_busy_literal", hz.md_busy, expBusy[0]);
    if (reset) begin
      busyEnd = cyc;
      mCnt = 0;
    end else begin
      if (hz.md_startE) busyEnd = cyc + (hz.md_opE ? 10 : 5);
      if (eStall && mCnt < 64'hFFFF_FFFF) mCnt++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idleInputs();
    hz.rsD = 0; hz.rtD = 0; hz.tuse_rsD = 3; hz.tuse_rtD = 3;
    hz.waE = 0; hz.regwE = 0; hz.tnewE = 0;
    hz.waM = 0; hz.regwM = 0; hz.tnewM = 0;
    hz.md_startE = 0; hz.md_opE = 0; hz.md_useD = 0;
  endtask

  initial begin
    idleInputs();
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    step(0, 0);
    reset = 1'b0;

    // load-use through E then M, then an rt-side hazard
    hz.waE = 5; hz.regwE = 1; hz.tnewE = 2; hz.rsD = 5; hz.tuse_rsD = 0;
    step(1, 0);
    hz.regwE = 0; hz.waE = 0; hz.tnewE = 0;
    hz.waM = 5; hz.regwM = 1; hz.tnewM = 1;
    step(1, 0);
    idleInputs();
    hz.waE = 7; hz.regwE = 1; hz.tnewE = 2; hz.rtD = 7; hz.tuse_rtD = 1;
    step(1, 0);
    hz.waM = 5; hz.regwM = 1; hz.tnewM = 0; hz.rsD = 5; hz.tuse_rsD = 0;
    hz.regwE = 0;
    step(0, 0);
`ifdef HAZARD_STALL_CNT_EN
    check("stall_cnt_three", stall_cnt, 32'd3);
`endif

    // writes to $0 and ready-in-time results never stall
    idleInputs();
    hz.waE = 0; hz.regwE = 1; hz.rsD = 0; hz.tnewE = 2; hz.tuse_rsD = 0;
    step(0, 0);
    hz.waE = 5; hz.tnewE = 1; hz.rsD = 5; hz.tuse_rsD = 1;
    step(0, 0);
    hz.tnewE = 3; hz.tuse_rsD = 3;
    step(0, 0);

    // mult: stall cycles 0..5, busy 1..5
    idleInputs();
    hz.md_useD = 1; hz.md_startE = 1; hz.md_opE = 0;
    step(1, 0);
    hz.md_startE = 0;
    for (int i = 1; i <= 5; i++) step(1, 1);
    step(0, 0);

    // div interrupted by reset in cycle 3
    hz.md_startE = 1; hz.md_opE = 1;
    step(1, 0);
    hz.md_startE = 0;
    step(1, 1);
    step(1, 1);
    reset = 1'b1;
    step(1, 1);
    reset = 1'b0;
    step(0, 0);
    step(0, 0);

    // reset beats a simultaneous start
    hz.md_useD = 0;
    reset = 1'b1; hz.md_startE = 1; hz.md_opE = 1;
    step(0, 0);
    reset = 1'b0; hz.md_startE = 0;
    step(0, 0);

    // last start wins: mult at c0, div at c3 keeps busy through c13
    hz.md_startE = 1; hz.md_opE = 0;
    step(-1, 0);
    hz.md_startE = 0;
    step(-1, 1);
    step(-1, 1);
    hz.md_startE = 1; hz.md_opE = 1;
    step(-1, 1);
    hz.md_startE = 0;
    for (int i = 4; i <= 13; i++) step(-1, 1);
    step(-1, 0);

`ifdef HAZARD_STALL_CNT_EN
    idleInputs();
    hz.waE = 5; hz.regwE = 1; hz.tnewE = 2; hz.rsD = 5; hz.tuse_rsD = 0;
    force dut.stall_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.stall_cnt;
    mCnt = 64'hFFFF_FFFF;
    step(1, -1);
    step(1, -1);
    check("stall_cnt_saturated", stall_cnt, 32'hFFFF_FFFF);
`endif

    idleInputs();
    for (int i = 0; i < 1500; i++) begin
      reset = ($urandom_range(0, 49) == 0);
      hz.rsD = 5'($urandom_range(0, 3));
      hz.rtD = 5'($urandom_range(0, 3));
      hz.tuse_rsD = 2'($urandom_range(0, 3));
      hz.tuse_rtD = 2'($urandom_range(0, 3));
      hz.waE = 5'($urandom_range(0, 3));
      hz.regwE = 1'($urandom_range(0, 1));
      hz.tnewE = 3'($urandom_range(0, 3));
      hz.waM = 5'($urandom_range(0, 3));
      hz.regwM = 1'($urandom_range(0, 1));
      hz.tnewM = 3'($urandom_range(0, 3));
      hz.md_startE = ($urandom_range(0, 7) == 0);
      hz.md_opE = 1'($urandom_range(0, 1));
      hz.md_useD = 1'($urandom_range(0, 1));
      step(-1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
